// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared state, op-class and PC-source encodings for the multicycle CPU
package mcpu_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;
  localparam logic [2:0] OP_ALU_R = 3'd0;
  localparam logic [2:0] OP_ALU_I = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STORE = 3'd3;
  localparam logic [2:0] OP_BEQ   = 3'd4;
  localparam logic [2:0] OP_JUMP  = 3'd5;
  localparam logic [2:0] OP_JAL   = 3'd6;
  localparam logic [2:0] OP_SYS   = 3'd7;
  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;
  localparam logic [1:0] PCSRC_REG = 2'd3;
endpackage

// File: rtl/mcpu_pc_sequencer.sv
// mcpu_pc_sequencer: multicycle control FSM driving PC load, memory handshakes and retire count
module mcpu_pc_sequencer
  import mcpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op_class,
  input  logic             op_sub,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             hold,
  output logic             pc_enable,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);
  state_t     cur, nxt;
  logic       retire, pe, irw, ireq, dreq, dwe, rw, hlt;
  logic [1:0] src;
  // next state and raw strobes; hold then freezes progress and masks the load strobes
  always_comb begin
    nxt = cur;
    retire = 1'b0;
    pe = 1'b0;
    src = PCSRC_SEQ;
    irw = 1'b0;
    ireq = 1'b0;
    dreq = 1'b0;
    dwe = 1'b0;
    rw = 1'b0;
    hlt = 1'b0;
    case (cur)
      S_FETCH: begin
        ireq = 1'b1;
        if (imem_ready) begin
          irw = 1'b1;
          pe = 1'b1;
          nxt = S_DECODE;
        end
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        case (op_class)
          OP_ALU_R, OP_ALU_I: nxt = S_WB;
          OP_LOAD, OP_STORE:  nxt = S_MEM;
          OP_BEQ: begin
            pe = zero;
            src = PCSRC_BR;
            nxt = S_FETCH;
            retire = 1'b1;
          end
          OP_JUMP, OP_JAL: begin
            pe = 1'b1;
            src = PCSRC_JMP;
            rw = (op_class == OP_JAL);
            nxt = S_FETCH;
            retire = 1'b1;
          end
          default: begin
            pe = op_sub;
            src = PCSRC_REG;
            nxt = op_sub ? S_FETCH : S_HALT;
            retire = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        dreq = 1'b1;
        dwe = (op_class == OP_STORE);
        if (dmem_ready) begin
          nxt = dwe ? S_FETCH : S_WB;
          retire = dwe;
        end
      end
      S_WB: begin
        rw = 1'b1;
        nxt = S_FETCH;
        retire = 1'b1;
      end
      S_HALT: hlt = 1'b1;
      default: nxt = S_FETCH;
    endcase
    if (hold && cur <= S_WB) begin
      nxt = cur;
      retire = 1'b0;
      pe = 1'b0;
      irw = 1'b0;
      rw = 1'b0;
    end
  end
  assign pc_enable = rst_n & pe;
  assign pc_src    = (rst_n & pe) ? src : PCSRC_SEQ;
  assign ir_write  = rst_n & irw;
  assign imem_req  = rst_n & ireq;
  assign dmem_req  = rst_n & dreq;
  assign dmem_we   = rst_n & dwe;
  assign reg_write = rst_n & rw;
  assign halted    = rst_n & hlt;
  assign state     = rst_n ? cur : 3'd0;
  // state register and free-running retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur <= S_FETCH;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mcpu_pc_sequencer.sv
// tb_mcpu_pc_sequencer: directed scenario bench for the multicycle PC sequencer
module tb_mcpu_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  op_class = '0;
  logic        op_sub = 1'b0, zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0, hold = 1'b0;
  logic        pc_enable, ir_write, imem_req, dmem_req, dmem_we, reg_write, halted;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic [31:0] retired;
  int tests = 0;
  int fails = 0;

  mcpu_pc_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_class(op_class), .op_sub(op_sub), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .hold(hold),
    .pc_enable(pc_enable), .pc_src(pc_src), .ir_write(ir_write), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write), .halted(halted),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] iv(input logic [2:0] oc, input logic sub, z, ir, dr, h);
    return {oc, sub, z, ir, dr, h};
  endfunction

  function automatic logic [11:0] ev(input logic pe, input logic [1:0] src, input logic irw, ireq,
                                     dreq, dwe, rw, hl, input logic [2:0] st);
    return {pe, src, irw, ireq, dreq, dwe, rw, hl, st};
  endfunction

  function automatic logic [11:0] outs();
    return {pc_enable, pc_src, ir_write, imem_req, dmem_req, dmem_we, reg_write, halted, state};
  endfunction

  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    {op_class, op_sub, zero, imem_ready, dmem_ready, hold} = v;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(iv(3'd0, 0, 0, 1, 0, 0));
      tests++;
      if (outs() !== 12'h000 || retired !== 32'd0) begin
        fails++;
        $display("FAIL reset[%0d]: outs=%h retired=%0d, want outs=000 retired=0", i, outs(), retired);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (outs() !== ev(1, 2'd0, 1, 1, 0, 0, 0, 0, 3'd0) || retired !== 32'd0) begin
      fails++;
      $display("FAIL first_fetch: outs=%h retired=%0d, want %h retired=0", outs(), retired,
               ev(1, 2'd0, 1, 1, 0, 0, 0, 0, 3'd0));
    end
  endtask

  task automatic test_alu();
    logic [7:0]  in_v [4];
    logic [11:0] ex_v [4];
    logic [31:0] rt_v [4];
    in_v = '{iv(3'd0, 0, 0, 0, 0, 0), iv(3'd0, 0, 0, 0, 0, 0), iv(3'd0, 0, 0, 0, 0, 0),
             iv(3'd0, 0, 0, 0, 0, 0)};
    ex_v = '{ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd1), ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd2),
             ev(0, 2'd0, 0, 0, 0, 0, 1, 0, 3'd4), ev(0, 2'd0, 0, 1, 0, 0, 0, 0, 3'd0)};
    rt_v = '{32'd0, 32'd0, 32'd0, 32'd1};
    for (int i = 0; i < 4; i++) begin
      drive(in_v[i]);
      tests++;
      if (outs() !== ex_v[i] || retired !== rt_v[i]) begin
        fails++;
        $display("FAIL alu[%0d]: outs=%h retired=%0d, want %h retired=%0d", i, outs(), retired, ex_v[i], rt_v[i]);
      end
    end
  endtask

  task automatic test_load();
    logic [7:0]  in_v [8];
    logic [11:0] ex_v [8];
    logic [31:0] rt_v [8];
    in_v = '{iv(3'd2, 0, 0, 1, 0, 0), iv(3'd2, 0, 0, 0, 0, 0), iv(3'd2, 0, 0, 0, 0, 0),
             iv(3'd2, 0, 0, 0, 0, 0), iv(3'd2, 0, 0, 0, 0, 0), iv(3'd2, 0, 0, 0, 1, 0),
             iv(3'd2, 0, 0, 0, 0, 0), iv(3'd2, 0, 0, 0, 0, 0)};
    ex_v = '{ev(1, 2'd0, 1, 1, 0, 0, 0, 0, 3'd0), ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd1),
             ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd2), ev(0, 2'd0, 0, 0, 1, 0, 0, 0, 3'd3),
             ev(0, 2'd0, 0, 0, 1, 0, 0, 0, 3'd3), ev(0, 2'd0, 0, 0, 1, 0, 0, 0, 3'd3),
             ev(0, 2'd0, 0, 0, 0, 0, 1, 0, 3'd4), ev(0, 2'd0, 0, 1, 0, 0, 0, 0, 3'd0)};
    rt_v = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
    for (int i = 0; i < 8; i++) begin
      drive(in_v[i]);
      tests++;
      if (outs() !== ex_v[i] || retired !== rt_v[i]) begin
        fails++;
        $display("FAIL load[%0d]: outs=%h retired=%0d, want %h retired=%0d", i, outs(), retired, ex_v[i], rt_v[i]);
      end
    end
  endtask

  task automatic test_beq();
    logic [7:0]  in_v [8];
    logic [11:0] ex_v [8];
    logic [31:0] rt_v [8];
    in_v = '{iv(3'd4, 0, 1, 1, 0, 0), iv(3'd4, 0, 1, 0, 0, 0), iv(3'd4, 0, 1, 0, 0, 0),
             iv(3'd4, 0, 0, 0, 0, 0), iv(3'd4, 0, 0, 1, 0, 0), iv(3'd4, 0, 0, 0, 0, 0),
             iv(3'd4, 0, 0, 0, 0, 0), iv(3'd4, 0, 0, 0, 0, 0)};
    ex_v = '{ev(1, 2'd0, 1, 1, 0, 0, 0, 0, 3'd0), ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd1),
             ev(1, 2'd1, 0, 0, 0, 0, 0, 0, 3'd2), ev(0, 2'd0, 0, 1, 0, 0, 0, 0, 3'd0),
             ev(1, 2'd0, 1, 1, 0, 0, 0, 0, 3'd0), ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd1),
             ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd2), ev(0, 2'd0, 0, 1, 0, 0, 0, 0, 3'd0)};
    rt_v = '{32'd2, 32'd2, 32'd2, 32'd3, 32'd3, 32'd3, 32'd3, 32'd4};
    for (int i = 0; i < 8; i++) begin
      drive(in_v[i]);
      tests++;
      if (outs() !== ex_v[i] || retired !== rt_v[i]) begin
        fails++;
        $display("FAIL beq[%0d]: outs=%h retired=%0d, want %h retired=%0d", i, outs(), retired, ex_v[i], rt_v[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0]  in_v [9];
    logic [11:0] ex_v [9];
    logic [31:0] rt_v [9];
    in_v = '{iv(3'd0, 0, 0, 1, 0, 1), iv(3'd0, 0, 0, 1, 0, 1), iv(3'd0, 0, 0, 1, 0, 0),
             iv(3'd0, 0, 0, 0, 0, 1), iv(3'd0, 0, 0, 0, 0, 0), iv(3'd0, 0, 0, 0, 0, 0),
             iv(3'd0, 0, 0, 0, 0, 1), iv(3'd0, 0, 0, 0, 0, 0), iv(3'd0, 0, 0, 0, 0, 0)};
    ex_v = '{ev(0, 2'd0, 0, 1, 0, 0, 0, 0, 3'd0), ev(0, 2'd0, 0, 1, 0, 0, 0, 0, 3'd0),
             ev(1, 2'd0, 1, 1, 0, 0, 0, 0, 3'd0), ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd1),
             ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd1), ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd2),
             ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd4), ev(0, 2'd0, 0, 0, 0, 0, 1, 0, 3'd4),
             ev(0, 2'd0, 0, 1, 0, 0, 0, 0, 3'd0)};
    rt_v = '{32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd5};
    for (int i = 0; i < 9; i++) begin
      drive(in_v[i]);
      tests++;
      if (outs() !== ex_v[i] || retired !== rt_v[i]) begin
        fails++;
        $display("FAIL hold[%0d]: outs=%h retired=%0d, want %h retired=%0d", i, outs(), retired, ex_v[i], rt_v[i]);
      end
    end
  endtask

  task automatic test_jr_jal_halt();
    logic [7:0]  in_v [12];
    logic [11:0] ex_v [12];
    logic [31:0] rt_v [12];
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (outs() !== 12'h000) begin
      fails++;
      $display("FAIL reset_mid: outs=%h, want 000", outs());
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_v = '{iv(3'd7, 1, 0, 1, 0, 0), iv(3'd7, 1, 0, 0, 0, 0), iv(3'd7, 1, 0, 0, 0, 0),
             iv(3'd6, 0, 0, 1, 0, 0), iv(3'd6, 0, 0, 0, 0, 0), iv(3'd6, 0, 0, 0, 0, 0),
             iv(3'd7, 0, 0, 1, 0, 0), iv(3'd7, 0, 0, 0, 0, 0), iv(3'd7, 0, 0, 0, 0, 0),
             iv(3'd7, 0, 0, 1, 1, 0), iv(3'd7, 0, 0, 1, 1, 1), iv(3'd0, 0, 1, 1, 1, 0)};
    ex_v = '{ev(1, 2'd0, 1, 1, 0, 0, 0, 0, 3'd0), ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd1),
             ev(1, 2'd3, 0, 0, 0, 0, 0, 0, 3'd2), ev(1, 2'd0, 1, 1, 0, 0, 0, 0, 3'd0),
             ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd1), ev(1, 2'd2, 0, 0, 0, 0, 1, 0, 3'd2),
             ev(1, 2'd0, 1, 1, 0, 0, 0, 0, 3'd0), ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd1),
             ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd2), ev(0, 2'd0, 0, 0, 0, 0, 0, 1, 3'd5),
             ev(0, 2'd0, 0, 0, 0, 0, 0, 1, 3'd5), ev(0, 2'd0, 0, 0, 0, 0, 0, 1, 3'd5)};
    rt_v = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd3, 32'd3, 32'd3};
    for (int i = 0; i < 12; i++) begin
      drive(in_v[i]);
      tests++;
      if (outs() !== ex_v[i] || retired !== rt_v[i]) begin
        fails++;
        $display("FAIL jr_jal_halt[%0d]: outs=%h retired=%0d, want %h retired=%0d", i, outs(), retired, ex_v[i], rt_v[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (outs() !== 12'h000) begin
      fails++;
      $display("FAIL halt_reset: outs=%h, want 000", outs());
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    tests++;
    if (outs() !== ev(1, 2'd0, 1, 1, 0, 0, 0, 0, 3'd0) || retired !== 32'd0) begin
      fails++;
      $display("FAIL halt_exit: outs=%h retired=%0d, want %h retired=0", outs(), retired,
               ev(1, 2'd0, 1, 1, 0, 0, 0, 0, 3'd0));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_beq();
    test_hold();
    test_jr_jal_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
